// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared constants for the 32-bit execute-stage ALU: operand width, shift
// amount width and the 3-bit opcode encodings.
// -----------------------------------------------------------------------------
package alu_pkg;

    // Operand/result width; the datapath only supports 32 bits.
    localparam int WIDTH    = 32;
    // Shift/extract amount width (log2 of WIDTH).
    localparam int SHAMT_W  = 5;
    // Opcode field width.
    localparam int OP_W     = 3;

    localparam logic [OP_W-1:0] OP_ADD = 3'b000;
    localparam logic [OP_W-1:0] OP_SUB = 3'b001;
    localparam logic [OP_W-1:0] OP_AND = 3'b010;
    localparam logic [OP_W-1:0] OP_OR  = 3'b011;
    localparam logic [OP_W-1:0] OP_XOR = 3'b100;
    localparam logic [OP_W-1:0] OP_SLL = 3'b101;
    localparam logic [OP_W-1:0] OP_SRA = 3'b110;
    localparam logic [OP_W-1:0] OP_EXT = 3'b111;

endpackage : alu_pkg

// File: rtl/alu32_if.sv
// -----------------------------------------------------------------------------
// alu32_if
// Operand/result bundle between the execute-stage issue logic and alu32.
//   in_valid  : operands/opcode valid this cycle
//   x, y      : operands A and B
//   z         : shift amount / extract field width
//   operation : opcode (see alu_pkg)
//   result    : registered result
//   overflow  : registered signed overflow flag
//   out_valid : result/overflow hold a new value this cycle
// master = issuing side, slave = alu32.
// -----------------------------------------------------------------------------
interface alu32_if;
    import alu_pkg::*;

    logic                 in_valid;
    logic [WIDTH-1:0]     x;
    logic [WIDTH-1:0]     y;
    logic [SHAMT_W-1:0]   z;
    logic [OP_W-1:0]      operation;
    logic [WIDTH-1:0]     result;
    logic                 overflow;
    logic                 out_valid;

    modport master (
        output in_valid, x, y, z, operation,
        input  result, overflow, out_valid
    );

    modport slave (
        input  in_valid, x, y, z, operation,
        output result, overflow, out_valid
    );

endinterface : alu32_if

// File: rtl/alu32_comb.sv
// -----------------------------------------------------------------------------
// alu32_comb
// Purely combinational ALU core: add/sub with signed overflow, bitwise logic,
// logical left shift, arithmetic right shift and low-field extract.
//   x, y      : operands
//   z         : shift amount / extract width (ignored by ADD..XOR)
//   operation : opcode
//   result_s  : computed result
//   overflow_s: signed overflow (ADD/SUB only, 0 otherwise)
// -----------------------------------------------------------------------------
module alu32_comb
    import alu_pkg::*;
(
    input  logic [WIDTH-1:0]   x,
    input  logic [WIDTH-1:0]   y,
    input  logic [SHAMT_W-1:0] z,
    input  logic [OP_W-1:0]    operation,
    output logic [WIDTH-1:0]   result_s,
    output logic               overflow_s
);

    logic [WIDTH-1:0] sum_s;
    logic [WIDTH-1:0] diff_s;
    logic [WIDTH-1:0] sll_s;
    logic [WIDTH-1:0] sra_s;
    logic [WIDTH-1:0] ext_mask_s;

    // Carry out of the adder is intentionally dropped (mod 2^32).
    assign sum_s  = x + y;
    assign diff_s = x - y;
    assign sll_s  = x << z;
    assign sra_s  = $unsigned($signed(x) >>> z);
    // z ranges 0..31, so 1<<z never overflows; z=0 gives an all-zero mask.
    assign ext_mask_s = (32'h0000_0001 << z) - 32'h0000_0001;

    // Opcode select of result and signed overflow flag.
    always_comb begin
        result_s   = {WIDTH{1'b0}};
        overflow_s = 1'b0;
        case (operation)
            OP_ADD: begin
                result_s   = sum_s;
                // Same-sign operands producing a different-sign sum.
                overflow_s = (x[WIDTH-1] == y[WIDTH-1]) && (sum_s[WIDTH-1] != x[WIDTH-1]);
            end
            OP_SUB: begin
                result_s   = diff_s;
                // Opposite-sign operands where the difference flips away from x.
                overflow_s = (x[WIDTH-1] != y[WIDTH-1]) && (diff_s[WIDTH-1] != x[WIDTH-1]);
            end
            OP_AND: begin
                result_s   = x & y;
                overflow_s = 1'b0;
            end
            OP_OR: begin
                result_s   = x | y;
                overflow_s = 1'b0;
            end
            OP_XOR: begin
                result_s   = x ^ y;
                overflow_s = 1'b0;
            end
            OP_SLL: begin
                result_s   = sll_s;
                overflow_s = 1'b0;
            end
            OP_SRA: begin
                result_s   = sra_s;
                overflow_s = 1'b0;
            end
            OP_EXT: begin
                result_s   = x & ext_mask_s;
                overflow_s = 1'b0;
            end
            default: begin
                result_s   = {WIDTH{1'b0}};
                overflow_s = 1'b0;
            end
        endcase
    end

endmodule : alu32_comb

// File: rtl/alu32.sv
// -----------------------------------------------------------------------------
// alu32
// Execute-stage 32-bit ALU with one-cycle latency. Wraps alu32_comb with the
// result/overflow/valid output registers.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (clears all outputs)
//   bus   : alu32_if.slave operand/result bundle
// Result and overflow are loaded only when in_valid is high and otherwise hold;
// out_valid is a one-cycle echo of in_valid.
// -----------------------------------------------------------------------------
module alu32
    import alu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    alu32_if.slave     bus
);

    logic [WIDTH-1:0] result_s;
    logic             overflow_s;
    logic [WIDTH-1:0] result_r;
    logic             overflow_r;
    logic             out_valid_r;

    alu32_comb u_comb (
        .x          (bus.x),
        .y          (bus.y),
        .z          (bus.z),
        .operation  (bus.operation),
        .result_s   (result_s),
        .overflow_s (overflow_s)
    );

    // Output registers: capture on in_valid, hold otherwise; reset clears all.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_r    <= {WIDTH{1'b0}};
            overflow_r  <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= bus.in_valid;
            if (bus.in_valid) begin
                result_r   <= result_s;
                overflow_r <= overflow_s;
            end else begin
                result_r   <= result_r;
                overflow_r <= overflow_r;
            end
        end
    end

    assign bus.result    = result_r;
    assign bus.overflow  = overflow_r;
    assign bus.out_valid = out_valid_r;

endmodule : alu32

// File: tb/tb_alu32.sv
// -----------------------------------------------------------------------------
// tb_alu32
// Directed-vector self-checking bench for alu32. Inputs change on the falling
// edge; outputs are sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_alu32;
    import alu_pkg::*;

    logic clk;
    logic rst_n;
    int   check_cnt;
    int   error_cnt;

    alu32_if bus ();

    alu32 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        if (obs !== exp) begin
            error_cnt++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one operation at the falling edge, then sample after the rising edge.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] sh);
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.operation = op;
        bus.x         = a;
        bus.y         = b;
        bus.z         = sh;
        @(posedge clk);
        #1;
    endtask

    // One idle cycle with in_valid low.
    task automatic run_gap();
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.x        = 32'h1234_5678;
        bus.y        = 32'h9ABC_DEF0;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [31:0] res, input logic ov);
        check_val({tag, "_res"}, bus.result, res);
        check_val({tag, "_ov"},  {31'd0, bus.overflow}, {31'd0, ov});
        check_val({tag, "_vld"}, {31'd0, bus.out_valid}, 32'd1);
    endtask

    initial begin
        check_cnt     = 0;
        error_cnt     = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b1;
        bus.operation = OP_ADD;
        bus.x         = 32'h0000_0005;
        bus.y         = 32'h0000_0003;
        bus.z         = 5'd0;

        // Reset held across edges with in_valid high: outputs stay clear.
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_res", bus.result, 32'h0);
        check_val("rst_ov",  {31'd0, bus.overflow}, 32'd0);
        check_val("rst_vld", {31'd0, bus.out_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Unsigned wrap is not a signed overflow.
        run_op(OP_ADD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd16);
        expect_out("add_wrap", 32'hFFFF_FFFE, 1'b0);

        // Mid-stream asynchronous reset with in_valid still high.
        #1 rst_n = 1'b0;
        #1;
        check_val("async_rst_res", bus.result, 32'h0);
        check_val("async_rst_ov",  {31'd0, bus.overflow}, 32'd0);
        check_val("async_rst_vld", {31'd0, bus.out_valid}, 32'd0);

        // Release with an operation already presented: result one cycle later.
        @(negedge clk);
        rst_n         = 1'b1;
        bus.in_valid  = 1'b1;
        bus.operation = OP_ADD;
        bus.x         = 32'h7FFF_FFFF;
        bus.y         = 32'h0000_0001;
        bus.z         = 5'd0;
        @(posedge clk);
        #1;
        expect_out("add_ovf", 32'h8000_0000, 1'b1);

        run_op(OP_ADD, 32'h0000_0002, 32'hFFFF_FFFE, 5'd0);
        expect_out("add_zero", 32'h0000_0000, 1'b0);
        run_op(OP_ADD, 32'h8000_0000, 32'h8000_0000, 5'd0);
        expect_out("add_negovf", 32'h0000_0000, 1'b1);
        run_op(OP_SUB, 32'h8000_0000, 32'h0000_0001, 5'd0);
        expect_out("sub_ovf", 32'h7FFF_FFFF, 1'b1);
        run_op(OP_SUB, 32'h0000_0005, 32'h0000_0007, 5'd0);
        expect_out("sub_neg", 32'hFFFF_FFFE, 1'b0);
        run_op(OP_AND, 32'h8000_0000, 32'h0000_0001, 5'd0);
        expect_out("and_noovf", 32'h0000_0000, 1'b0);

        // Shifts; y carries junk to confirm it is ignored.
        run_op(OP_SLL, 32'h8000_0001, 32'hFFFF_FFFF, 5'd4);
        expect_out("sll4", 32'h0000_0010, 1'b0);
        run_op(OP_SRA, 32'h8000_0001, 32'hFFFF_FFFF, 5'd4);
        expect_out("sra4", 32'hF800_0000, 1'b0);
        run_op(OP_SRA, 32'h8000_0001, 32'h0000_0000, 5'd0);
        expect_out("sra0", 32'h8000_0001, 1'b0);
        run_op(OP_SRA, 32'h4000_0000, 32'h0000_0000, 5'd31);
        expect_out("sra31_pos", 32'h0000_0000, 1'b0);

        // Extract boundaries.
        run_op(OP_EXT, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 5'd16);
        expect_out("ext16", 32'h0000_BEEF, 1'b0);
        run_op(OP_EXT, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 5'd0);
        expect_out("ext0", 32'h0000_0000, 1'b0);
        run_op(OP_EXT, 32'hDEAD_BEEF, 32'h0000_0000, 5'd31);
        expect_out("ext31", 32'h5EAD_BEEF, 1'b0);

        // Stream with single-cycle gaps: ordering, valid drop and hold.
        run_op(OP_XOR, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd7);
        expect_out("str_xor", 32'h0FF0_0FF0, 1'b0);
        run_gap();
        check_val("gap1_vld", {31'd0, bus.out_valid}, 32'd0);
        check_val("gap1_hold", bus.result, 32'h0FF0_0FF0);
        run_op(OP_OR, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd7);
        expect_out("str_or", 32'hFFF0_FFF0, 1'b0);
        run_gap();
        check_val("gap2_vld", {31'd0, bus.out_valid}, 32'd0);
        check_val("gap2_hold", bus.result, 32'hFFF0_FFF0);
        run_op(OP_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd7);
        expect_out("str_and", 32'hF000_F000, 1'b0);

        // Overflow flag holds across an idle cycle too.
        run_op(OP_ADD, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 5'd0);
        expect_out("add_ovf2", 32'hFFFF_FFFE, 1'b1);
        run_gap();
        check_val("gap3_ov_hold", {31'd0, bus.overflow}, 32'd1);
        check_val("gap3_vld", {31'd0, bus.out_valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", check_cnt, error_cnt);
        $finish;
    end

endmodule : tb_alu32
